// File: rtl/hv_reg_bank.sv
// hv_reg_bank: shadow/active HV code bank with commit sequencer; define HV_RAMP_EN to limit each LATCH step to RAMP_STEP
module hv_reg_bank #(
    parameter int         UPDATE_CYCLES = 200,
    parameter logic [9:0] RAMP_STEP     = 10'd16
) (
    input  logic         reset,
    input  logic         dac_sclk_i,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [9:0]   wr_data,
    input  logic         commit,
    input  logic [4:0]   rd_addr,
    output logic [9:0]   rd_data,
    output logic [319:0] hv_reg_din,
    output logic         hv_update,
    output logic         busy,
    output logic         pending
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_LATCH = 4'b0010,
        S_PULSE = 4'b0100,
        S_WAIT  = 4'b1000
    } state_t;

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic [9:0] shadow      [32];
    logic [9:0] active      [32];
    logic [9:0] next_active [32];
    logic       wait_done;
    logic       mismatch;

    assign wait_done = (state == S_WAIT) && (wait_cnt == 8'(UPDATE_CYCLES - 1));

    always_ff @(posedge dac_sclk_i or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= next_state;

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = (commit || pending) ? S_LATCH : S_IDLE;
            S_LATCH: next_state = S_PULSE;
            S_PULSE: next_state = S_WAIT;
            S_WAIT:  next_state = wait_done ? S_IDLE : S_WAIT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        hv_update = state == S_PULSE;
        busy      = state != S_IDLE;
    end

    always_ff @(posedge dac_sclk_i or negedge reset)
        if (!reset) wait_cnt <= '0;
        else wait_cnt <= (state == S_WAIT && !wait_done) ? wait_cnt + 8'd1 : 8'd0;

    // an IDLE cycle either launches the update or has nothing queued, so pending only survives while busy
    always_ff @(posedge dac_sclk_i or negedge reset)
        if (!reset) pending <= 1'b0;
        else pending <= busy && (pending || commit || (wait_done && mismatch));

    always_ff @(posedge dac_sclk_i or negedge reset)
        if (!reset) begin
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) shadow[wr_addr] <= wr_data;
            rd_data <= shadow[rd_addr];
        end

`ifdef HV_RAMP_EN
    function automatic logic [9:0] ramp(input logic [9:0] a, input logic [9:0] s);
        return (s > a) ? ((s - a > RAMP_STEP) ? a + RAMP_STEP : s)
                       : ((a - s > RAMP_STEP) ? a - RAMP_STEP : s);
    endfunction
`endif

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < 32; i++) begin
`ifdef HV_RAMP_EN
            next_active[i] = ramp(active[i], shadow[i]);
            mismatch = mismatch | (active[i] != shadow[i]);
`else
            next_active[i] = shadow[i];
`endif
        end
    end

    always_ff @(posedge dac_sclk_i or negedge reset)
        if (!reset) for (int i = 0; i < 32; i++) active[i] <= '0;
        else if (state == S_LATCH) for (int i = 0; i < 32; i++) active[i] <= next_active[i];

    for (genvar g = 0; g < 32; g++) begin : g_din
        assign hv_reg_din[10*g +: 10] = active[g];
    end
endmodule

// File: tb/tb_hv_reg_bank.sv
// tb_hv_reg_bank: randomized scoreboard bench for hv_reg_bank against a cycle-timeline reference model
module tb_hv_reg_bank;
    localparam int UC   = 200;
    localparam int STEP = 16;

    logic         reset = 1'b1, dac_sclk_i = 1'b0, wr_en = 1'b0, commit = 1'b0;
    logic [4:0]   wr_addr = '0, rd_addr = '0;
    logic [9:0]   wr_data = '0, rd_data;
    logic [319:0] hv_reg_din;
    logic         hv_update, busy, pending;
    int           cyc = 0, tests = 0, fails = 0, pulses = 0;

    typedef struct {
        int           cyc;
        logic         busy;
        logic         pending;
        logic         upd;
        logic [319:0] bank;
    } cyc_exp_t;
    typedef struct {
        int         cyc;
        logic [9:0] data;
    } rd_exp_t;

    cyc_exp_t     cq[$];
    rd_exp_t      rq[$];
    logic [319:0] pq[$];

    // reference model: shadow/active contents plus update timeline as absolute cycle numbers
    logic [9:0] m_sh [32];
    logic [9:0] m_act [32];
    int         m_lat, m_idle, m_next;
    bit         m_pend;

    hv_reg_bank #(.UPDATE_CYCLES(UC)) dut (
        .reset(reset), .dac_sclk_i(dac_sclk_i), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .rd_addr(rd_addr), .rd_data(rd_data),
        .hv_reg_din(hv_reg_din), .hv_update(hv_update), .busy(busy), .pending(pending)
    );

    always #5 dac_sclk_i = ~dac_sclk_i;
    always @(posedge dac_sclk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [319:0] pack(input logic [9:0] a [32]);
        logic [319:0] v;
        for (int i = 0; i < 32; i++) v[10*i +: 10] = a[i];
        return v;
    endfunction

    function automatic logic [9:0] toward(input int a, input int s);
`ifdef HV_RAMP_EN
        int d;
        d = s - a;
        if (d > STEP) d = STEP;
        else if (d < -STEP) d = -STEP;
        return 10'(a + d);
`else
        return (a == s) ? 10'(a) : 10'(s);
`endif
    endfunction

    function automatic logic [4:0] r5();
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic model_init();
        for (int i = 0; i < 32; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_lat  = -100000;
        m_idle = -100000;
        m_next = -1;
        m_pend = 0;
    endtask

    task automatic step(input bit we, input logic [4:0] wa, input logic [9:0] wd, input bit cm, input logic [4:0] ra);
        cyc_exp_t r;
        bit       bz;
        r.cyc  = cyc;
        r.bank = pack(m_act);
        r.upd  = (cyc == m_lat + 1);
        if (cyc == m_next) begin
            m_pend = 0;
            m_lat  = cyc;
            m_idle = cyc + 2 + UC;
            m_next = -1;
            for (int i = 0; i < 32; i++) m_act[i] = toward(int'(m_act[i]), int'(m_sh[i]));
            pq.push_back(pack(m_act));
        end
        bz        = cyc >= m_lat && cyc < m_idle;
        r.busy    = bz;
        r.pending = m_pend;
        cq.push_back(r);
`ifdef HV_RAMP_EN
        if (cyc == m_idle - 1 && pack(m_act) != pack(m_sh)) m_pend = 1;
`endif
        rq.push_back('{cyc + 1, m_sh[ra]});
        if (we) m_sh[wa] = wd;
        if (cm && bz) m_pend = 1;
        if (!bz && (cm || m_pend)) m_next = cyc + 1;
        wr_en = we; wr_addr = wa; wr_data = wd; commit = cm; rd_addr = ra;
        @(posedge dac_sclk_i);
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 5'd0, 10'd0, 0, r5());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_rd_data", 320'(rd_data), 320'd0);
        chk("rst_hv_reg_din", hv_reg_din, 320'd0);
        chk("rst_busy", 320'(busy), 320'd0);
        chk("rst_pending", 320'(pending), 320'd0);
        chk("rst_hv_update", 320'(hv_update), 320'd0);
        cq.delete();
        rq.delete();
        pq.delete();
        model_init();
        @(posedge dac_sclk_i);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge dac_sclk_i) begin : monitor
        cyc_exp_t r;
        rd_exp_t  q;
        if (reset) begin
            if (cq.size() != 0 && cq[0].cyc == cyc) begin
                r = cq.pop_front();
                chk("busy", 320'(busy), 320'(r.busy));
                chk("pending", 320'(pending), 320'(r.pending));
                chk("hv_update", 320'(hv_update), 320'(r.upd));
                chk("hv_reg_din", hv_reg_din, r.bank);
            end
            if (rq.size() != 0 && rq[0].cyc == cyc) begin
                q = rq.pop_front();
                chk("rd_data", 320'(rd_data), 320'(q.data));
            end
            if (hv_update) begin
                pulses++;
                if (pq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pulse_unqueued @cycle %0d: got hv_update=1 expected no update", cyc);
                end else chk("pulse_bank", hv_reg_din, pq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, p0;
        model_init();
        @(posedge dac_sclk_i);
        #1;
        do_reset();

        // write ch3 then commit
        step(1, 5'd3, 10'h155, 0, r5());
        p0 = pulses;
        step(0, 5'd0, 10'd0, 1, 5'd3);
        idle(UC + 6);
        chk("ch3_latched", 320'(hv_reg_din[39:30]), 320'(10'h155));
        chk("ch3_one_pulse", 320'(pulses - p0), 320'd1);

        // commit in PULSE and again at WAIT cycle 50 coalesce into one further update
        t = cyc; p0 = pulses;
        step(0, 5'd0, 10'd0, 1, r5());
        while (cyc < t + 2 * UC + 12) step(0, 5'd0, 10'd0, cyc == t + 2 || cyc == t + 53, r5());
        chk("coalesce_pulses", 320'(pulses - p0), 320'd2);

        // write ch0 during WAIT: readable at once, not active until next LATCH
        t = cyc;
        step(0, 5'd0, 10'd0, 1, r5());
        while (cyc < t + UC + 8) step(cyc == t + 13, 5'd0, 10'h3FF, 0, (cyc == t + 14) ? 5'd0 : r5());
        chk("ch0_held", 320'(hv_reg_din[9:0]), 320'd0);
        step(0, 5'd0, 10'd0, 1, 5'd0);
        idle(UC + 6);
        chk("ch0_latched", 320'(hv_reg_din[9:0]), 320'(10'h3FF));

        // commit on the last WAIT cycle is queued and serviced
        t = cyc; p0 = pulses;
        step(0, 5'd0, 10'd0, 1, r5());
        while (cyc < t + 2 * UC + 12) step(0, 5'd0, 10'd0, cyc == t + 2 + UC, r5());
        chk("wait_exit_commit_pulses", 320'(pulses - p0), 320'd2);

        // reset at WAIT cycle 100 aborts the update
        t = cyc; p0 = pulses;
        step(1, 5'd9, 10'h2AA, 0, r5());
        step(0, 5'd0, 10'd0, 1, r5());
        while (cyc < t + 4 + 100) step(0, 5'd0, 10'd0, cyc == t + 50, r5());
        do_reset();
        idle(UC + 10);
        chk("abort_pulses", 320'(pulses - p0), 320'd1);

        repeat (1500) step($urandom_range(0, 2) == 0, r5(), 10'($urandom), $urandom_range(0, 39) == 0, r5());
        do_reset();

`ifdef HV_RAMP_EN
        p0 = pulses;
        step(1, 5'd31, 10'd40, 0, r5());
        step(0, 5'd0, 10'd0, 1, 5'd31);
        idle(3 * (UC + 3) + 10);
        chk("ramp_up_final", 320'(hv_reg_din[319:310]), 320'd40);
        chk("ramp_up_pulses", 320'(pulses - p0), 320'd3);
        chk("ramp_up_idle", 320'(busy), 320'd0);
        step(1, 5'd5, 10'd40, 0, r5());
        step(0, 5'd0, 10'd0, 1, 5'd5);
        idle(3 * (UC + 3) + 10);
        p0 = pulses;
        step(1, 5'd5, 10'd0, 0, r5());
        step(0, 5'd0, 10'd0, 1, 5'd5);
        idle(3 * (UC + 3) + 10);
        chk("ramp_down_final", 320'(hv_reg_din[59:50]), 320'd0);
        chk("ramp_down_pulses", 320'(pulses - p0), 320'd3);
`endif

        idle(UC + 10);
        chk("updates_drained", 320'(pq.size()), 320'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
